// File: rtl/icw_ocw_write_sequencer.sv
// icw_ocw_write_sequencer
// Classifies each CPU write to the 8259A-compatible controller as ICW1-4 or
// OCW1-3 and walks the ICW1 -> ICW2 -> [ICW3] -> [ICW4] -> ready sequence.
// Every accepted write produces a single registered command strobe together
// with the latched data byte, one cycle after write_strobe is sampled.
module icw_ocw_write_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       write_strobe,
    input  logic       address_0,
    input  logic [7:0] data_in,
    output logic [7:0] internal_data_bus,
    output logic       icw1_strobe,
    output logic       icw2_strobe,
    output logic       icw3_strobe,
    output logic       icw4_strobe,
    output logic       icw_2_4_strobe,
    output logic       ocw1_strobe,
    output logic       ocw2_strobe,
    output logic       ocw3_strobe,
    output logic       initialized,
    output logic [2:0] init_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    localparam int IDX_ICW1 = 0;
    localparam int IDX_ICW2 = 1;
    localparam int IDX_ICW3 = 2;
    localparam int IDX_ICW4 = 3;
    localparam int IDX_OCW1 = 4;
    localparam int IDX_OCW2 = 5;
    localparam int IDX_OCW3 = 6;

    state_t     state_q, state_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [7:0] data_q, data_d;
    logic [6:0] strobe_q, strobe_d;
    logic       icw24_q, icw24_d;
    logic       init_q, init_d;

    // Decode the current write against the sequence position and work out
    // the next state, the strobe to fire and whether the byte is latched.
    always_comb begin
        state_d  = state_q;
        sngl_d   = sngl_q;
        ic4_d    = ic4_q;
        data_d   = data_q;
        strobe_d = '0;

        if (write_strobe) begin
            if (!address_0 && data_in[4]) begin
                // ICW1 always restarts the sequence, whatever state we are in
                strobe_d[IDX_ICW1] = 1'b1;
                sngl_d             = data_in[1];
                ic4_d              = data_in[0];
                state_d            = WAIT_ICW2;
            end else if (!address_0) begin
                // OCW2/OCW3 are only meaningful once initialization is done
                if (state_q == READY) begin
                    if (data_in[3]) begin
                        strobe_d[IDX_OCW3] = 1'b1;
                    end else begin
                        strobe_d[IDX_OCW2] = 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    WAIT_ICW2: begin
                        strobe_d[IDX_ICW2] = 1'b1;
                        if (!sngl_q) begin
                            state_d = WAIT_ICW3;
                        end else if (ic4_q) begin
                            state_d = WAIT_ICW4;
                        end else begin
                            state_d = READY;
                        end
                    end
                    WAIT_ICW3: begin
                        strobe_d[IDX_ICW3] = 1'b1;
                        state_d            = ic4_q ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: begin
                        strobe_d[IDX_ICW4] = 1'b1;
                        state_d            = READY;
                    end
                    READY: begin
                        strobe_d[IDX_OCW1] = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (strobe_d != '0) begin
            data_d = data_in;
        end

        icw24_d = strobe_d[IDX_ICW2] | strobe_d[IDX_ICW3] | strobe_d[IDX_ICW4];
        init_d  = (state_d == READY);
    end

    // Register sequence state and all outputs so they change together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sngl_q   <= 1'b0;
            ic4_q    <= 1'b0;
            data_q   <= 8'h00;
            strobe_q <= '0;
            icw24_q  <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sngl_q   <= sngl_d;
            ic4_q    <= ic4_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            icw24_q  <= icw24_d;
            init_q   <= init_d;
        end
    end

    assign internal_data_bus = data_q;
    assign icw1_strobe       = strobe_q[IDX_ICW1];
    assign icw2_strobe       = strobe_q[IDX_ICW2];
    assign icw3_strobe       = strobe_q[IDX_ICW3];
    assign icw4_strobe       = strobe_q[IDX_ICW4];
    assign ocw1_strobe       = strobe_q[IDX_OCW1];
    assign ocw2_strobe       = strobe_q[IDX_OCW2];
    assign ocw3_strobe       = strobe_q[IDX_OCW3];
    assign icw_2_4_strobe    = icw24_q;
    assign initialized       = init_q;
    assign init_state        = state_q;

endmodule

// File: tb/tb_icw_ocw_write_sequencer.sv
// tb_icw_ocw_write_sequencer
// Scoreboard bench: each issued write that should be accepted pushes its
// expected strobe/data/state into a queue, and a monitor pops and compares
// whenever the sequencer raises any command strobe.
module tb_icw_ocw_write_sequencer;

    logic       clk;
    logic       reset_n;
    logic       write_strobe;
    logic       address_0;
    logic [7:0] data_in;
    logic [7:0] internal_data_bus;
    logic       icw1_strobe, icw2_strobe, icw3_strobe, icw4_strobe;
    logic       icw_2_4_strobe;
    logic       ocw1_strobe, ocw2_strobe, ocw3_strobe;
    logic       initialized;
    logic [2:0] init_state;

    localparam logic [6:0] S_NONE = 7'h00;
    localparam logic [6:0] S_ICW1 = 7'h01;
    localparam logic [6:0] S_ICW2 = 7'h02;
    localparam logic [6:0] S_ICW3 = 7'h04;
    localparam logic [6:0] S_ICW4 = 7'h08;
    localparam logic [6:0] S_OCW1 = 7'h10;
    localparam logic [6:0] S_OCW2 = 7'h20;
    localparam logic [6:0] S_OCW3 = 7'h40;

    typedef struct packed {
        logic [6:0] strobes;
        logic [7:0] data;
        logic [2:0] state;
        logic       init;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] actStrobes;
    assign actStrobes = {ocw3_strobe, ocw2_strobe, ocw1_strobe,
                         icw4_strobe, icw3_strobe, icw2_strobe, icw1_strobe};

    icw_ocw_write_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .write_strobe      (write_strobe),
        .address_0         (address_0),
        .data_in           (data_in),
        .internal_data_bus (internal_data_bus),
        .icw1_strobe       (icw1_strobe),
        .icw2_strobe       (icw2_strobe),
        .icw3_strobe       (icw3_strobe),
        .icw4_strobe       (icw4_strobe),
        .icw_2_4_strobe    (icw_2_4_strobe),
        .ocw1_strobe       (ocw1_strobe),
        .ocw2_strobe       (ocw2_strobe),
        .ocw3_strobe       (ocw3_strobe),
        .initialized       (initialized),
        .init_state        (init_state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkResult(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Compare steady-state outputs (no strobe expected) at the current time
    task automatic checkOutput(input string name, input logic [2:0] expState,
                               input logic expInit, input logic [7:0] expBus);
        checkResult({name, " state"}, 32'(init_state), 32'(expState));
        checkResult({name, " initialized"}, 32'(initialized), 32'(expInit));
        checkResult({name, " strobes"}, 32'({actStrobes, icw_2_4_strobe}), 32'h0);
        checkResult({name, " bus"}, 32'(internal_data_bus), 32'(expBus));
    endtask

    // Drive one write at a falling edge; accepted writes queue their response
    task automatic applyStimulus(input logic a0, input logic [7:0] d, input logic [6:0] expStrobe,
                                 input logic [2:0] expState, input logic expInit);
        exp_t e;
        @(negedge clk);
        write_strobe = 1'b1;
        address_0    = a0;
        data_in      = d;
        if (expStrobe != S_NONE) begin
            e.strobes = expStrobe;
            e.data    = d;
            e.state   = expState;
            e.init    = expInit;
            expQ.push_back(e);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        write_strobe = 1'b0;
        address_0    = 1'b0;
        data_in      = 8'h00;
    endtask

    // Monitor: any strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (actStrobes != S_NONE)) begin
            if (expQ.size() == 0) begin
                checkResult("unexpected strobe", 32'(actStrobes), 32'(S_NONE));
            end else begin
                e = expQ.pop_front();
                checkResult("strobe", 32'(actStrobes), 32'(e.strobes));
                checkResult("icw_2_4", 32'(icw_2_4_strobe),
                            32'(|(e.strobes & (S_ICW2 | S_ICW3 | S_ICW4))));
                checkResult("data bus", 32'(internal_data_bus), 32'(e.data));
                checkResult("strobe state", 32'(init_state), 32'(e.state));
                checkResult("strobe initialized", 32'(initialized), 32'(e.init));
            end
        end
    end

    // Watchdog so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        write_strobe = 1'b0;
        address_0    = 1'b0;
        data_in      = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset", 3'd0, 1'b0, 8'h00);
        reset_n = 1'b1;

        // Writes in IDLE other than ICW1 are ignored
        applyStimulus(1'b1, 8'hFF, S_NONE, 3'd0, 1'b0);
        applyStimulus(1'b0, 8'h20, S_NONE, 3'd0, 1'b0);
        idleCycle();
        @(negedge clk);
        checkOutput("idle ignore", 3'd0, 1'b0, 8'h00);

        // Single mode, no ICW4
        applyStimulus(1'b0, 8'h12, S_ICW1, 3'd1, 1'b0);
        applyStimulus(1'b1, 8'h20, S_ICW2, 3'd4, 1'b1);
        idleCycle();
        @(negedge clk);
        checkOutput("single done", 3'd4, 1'b1, 8'h20);

        // OCW decode in READY, back-to-back
        applyStimulus(1'b1, 8'hFB, S_OCW1, 3'd4, 1'b1);
        applyStimulus(1'b0, 8'h20, S_OCW2, 3'd4, 1'b1);
        applyStimulus(1'b0, 8'h0B, S_OCW3, 3'd4, 1'b1);
        idleCycle();
        @(negedge clk);
        checkOutput("ready ocw", 3'd4, 1'b1, 8'h0B);

        // Cascade with ICW4, started from READY
        applyStimulus(1'b0, 8'h11, S_ICW1, 3'd1, 1'b0);
        applyStimulus(1'b1, 8'h08, S_ICW2, 3'd2, 1'b0);
        applyStimulus(1'b1, 8'h04, S_ICW3, 3'd3, 1'b0);
        applyStimulus(1'b1, 8'h01, S_ICW4, 3'd4, 1'b1);
        idleCycle();
        @(negedge clk);
        checkOutput("cascade done", 3'd4, 1'b1, 8'h01);

        // OCW-shaped write in WAIT_ICW2 is ignored
        applyStimulus(1'b0, 8'h12, S_ICW1, 3'd1, 1'b0);
        applyStimulus(1'b0, 8'h0A, S_NONE, 3'd1, 1'b0);
        idleCycle();
        @(negedge clk);
        checkOutput("wait2 ignore", 3'd1, 1'b0, 8'h12);

        // Restart from WAIT_ICW3; new sngl=1, ic4=1 go straight to WAIT_ICW4
        applyStimulus(1'b0, 8'h11, S_ICW1, 3'd1, 1'b0);
        applyStimulus(1'b1, 8'h08, S_ICW2, 3'd2, 1'b0);
        applyStimulus(1'b0, 8'h13, S_ICW1, 3'd1, 1'b0);
        applyStimulus(1'b1, 8'hAA, S_ICW2, 3'd3, 1'b0);
        idleCycle();
        @(negedge clk);
        checkOutput("restart", 3'd3, 1'b0, 8'hAA);

        // Async reset in WAIT_ICW4 while an ICW4 strobe is pending
        @(negedge clk);
        write_strobe = 1'b1;
        address_0    = 1'b1;
        data_in      = 8'h55;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
        address_0    = 1'b0;
        data_in      = 8'h00;
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset", 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("after reset", 3'd0, 1'b0, 8'h00);

        repeat (2) @(negedge clk);
        checkResult("pending expectations", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
